jts16_busmaster: RTL and testbench

- Initiator side of the 68000-style asynchronous bus: turns a simple one-word req/ack interface into a full AS/UDS/LDS/RnW bus cycle and waits for DTACKn from the target's DTACK generator.
- Used by on-chip masters (sprite/palette DMA, sub-CPU bridge, test masters) sharing the main 68000 bus; timing is paced by the same cpu_cen/cpu_cenb enables as the CPU.
- A zero-wait cycle lasts 4 CPU clocks, matching a 68000 bus cycle.

---
 rtl/jts16_bus_pkg.sv | 26 ++
 rtl/jts16_bus_timeout.sv | 43 ++++
 rtl/jts16_busmaster.sv | 232 +++++++++++++++++++++++
 tb/tb_jts16_busmaster.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jts16_bus_pkg.sv
// Shared types and constants for the jts16 bus-master block.
// The state enum, the byte-strobe encodings and the DTACK timeout counter
// width are used by jts16_busmaster and jts16_bus_timeout.
package jts16_bus_pkg;

    // Bus-cycle states, one per 68000 half-clock phase plus the abort path
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        S4    = 3'd4,
        S5    = 3'd5,
        S6    = 3'd6,
        ABORT = 3'd7
    } bus_state_e;

    // Active-low byte strobes {UDSn,LDSn}
    localparam logic [1:0] DSN_WORD = 2'b00;
    localparam logic [1:0] DSN_HI   = 2'b01;
    localparam logic [1:0] DSN_LO   = 2'b10;

    // Width of the DTACK wait counter (TIMEOUT range 1..1023)
    localparam int TIMEOUT_W = 10;

endpackage

// File: rtl/jts16_bus_timeout.sv
// Saturating DTACK wait counter for jts16_busmaster.
// last_o flags that the next increment reaches LIMIT, so the bus master can
// branch to ABORT on the same CPU half-clock that takes the final sample.
// Only instantiated when JTS16_BUSMASTER_TIMEOUT_EN is defined.
module jts16_bus_timeout
    import jts16_bus_pkg::*;
#(
    parameter logic [TIMEOUT_W-1:0] LIMIT = 10'd255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic [TIMEOUT_W-1:0] cnt_inc;

    // Next count: clear wins over increment, increment saturates at all-ones
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    assign last_o = (cnt_inc >= LIMIT);

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jts16_busmaster.sv
// jts16_busmaster: initiator side of the 68000-style asynchronous bus.
// Converts a one-word req/ack request into an AS/UDS/LDS/RnW bus cycle paced
// by cpu_cen/cpu_cenb and waits for DTACKn; a zero-wait cycle takes 4 CPU clocks.
// Optional feature macro JTS16_BUSMASTER_TIMEOUT_EN: when defined, a DTACKn
// timeout of TIMEOUT CPU clocks aborts the cycle and pulses err; when
// undefined, S3 waits forever and err is tied low.
module jts16_busmaster
    import jts16_bus_pkg::*;
#(
    parameter int AW      = 23,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_cenb,
    // request side
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    input  logic [1:0]    dsn,
    output logic [15:0]   dout,
    output logic          ack,
    output logic          err,
    output logic          busy,
    // 68000 bus side
    output logic [AW-1:0] A,
    output logic [15:0]   bus_dout,
    input  logic [15:0]   bus_din,
    output logic          RnW,
    output logic          ASn,
    output logic          UDSn,
    output logic          LDSn,
    input  logic          DTACKn
);

    bus_state_e    state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [15:0]   bdout_q, bdout_d;
    logic [15:0]   dout_q, dout_d;
    logic [1:0]    dsn_q, dsn_d;
    logic          rnw_q, rnw_d;
    logic          asn_q, asn_d;
    logic          udsn_q, udsn_d;
    logic          ldsn_q, ldsn_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

`ifdef JTS16_BUSMASTER_TIMEOUT_EN
    logic          err_q, err_d;
    logic          to_inc, to_clr, to_last;

    jts16_bus_timeout #(
        .LIMIT (TIMEOUT_W'(TIMEOUT))
    ) u_timeout (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (to_clr),
        .inc_i  (to_inc),
        .last_o (to_last)
    );

    assign err = err_q;
`else
    // TIMEOUT stays on the parameter list so both builds share one interface
    logic          unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    // Next-state and bus outputs; every state waits for its own CPU clock phase
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bdout_d = bdout_q;
        dout_d  = dout_q;
        dsn_d   = dsn_q;
        rnw_d   = rnw_q;
        asn_d   = asn_q;
        udsn_d  = udsn_q;
        ldsn_d  = ldsn_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
`ifdef JTS16_BUSMASTER_TIMEOUT_EN
        err_d   = 1'b0;
        to_inc  = 1'b0;
        to_clr  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A target still holding DTACKn from a previous cycle blocks the start
                if (cpu_cen && req && DTACKn) begin
                    a_d     = addr;
                    bdout_d = din;
                    dsn_d   = dsn;
                    rnw_d   = ~we;
                    busy_d  = 1'b1;
                    state_d = S1;
                end
            end
            S1: begin
                if (cpu_cenb) begin
                    asn_d = 1'b0;
                    // Reads drive the data strobes together with AS
                    if (rnw_q) begin
                        udsn_d = dsn_q[1];
                        ldsn_d = dsn_q[0];
                    end
                    state_d = S2;
                end
            end
            S2: begin
                if (cpu_cen) begin
                    // Writes drive the data strobes half a clock after AS
                    if (!rnw_q) begin
                        udsn_d = dsn_q[1];
                        ldsn_d = dsn_q[0];
                    end
                    state_d = S3;
                end
            end
            S3: begin
                if (cpu_cenb) begin
                    if (!DTACKn) begin
                        state_d = S4;
                    end
`ifdef JTS16_BUSMASTER_TIMEOUT_EN
                    else begin
                        to_inc = 1'b1;
                        if (to_last) begin
                            state_d = ABORT;
                        end
                    end
`endif
                end
            end
            S4: begin
                if (cpu_cen) begin
                    state_d = S5;
                end
            end
            S5: begin
                if (cpu_cenb) begin
                    if (rnw_q) begin
                        dout_d = bus_din;
                    end
                    asn_d   = 1'b1;
                    udsn_d  = 1'b1;
                    ldsn_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S6;
                end
            end
            S6: begin
                // Wait for the target to release DTACKn before freeing the bus
                if (cpu_cen && DTACKn) begin
                    rnw_d   = 1'b1;
                    busy_d  = 1'b0;
`ifdef JTS16_BUSMASTER_TIMEOUT_EN
                    to_clr  = 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            ABORT: begin
                asn_d   = 1'b1;
                udsn_d  = 1'b1;
                ldsn_d  = 1'b1;
                rnw_d   = 1'b1;
`ifdef JTS16_BUSMASTER_TIMEOUT_EN
                err_d   = 1'b1;
`endif
                state_d = S6;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers; reset releases every strobe on the next clock
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bdout_q <= '0;
            dout_q  <= '0;
            dsn_q   <= 2'b11;
            rnw_q   <= 1'b1;
            asn_q   <= 1'b1;
            udsn_q  <= 1'b1;
            ldsn_q  <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bdout_q <= bdout_d;
            dout_q  <= dout_d;
            dsn_q   <= dsn_d;
            rnw_q   <= rnw_d;
            asn_q   <= asn_d;
            udsn_q  <= udsn_d;
            ldsn_q  <= ldsn_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

`ifdef JTS16_BUSMASTER_TIMEOUT_EN
    // Timeout error pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign A        = a_q;
    assign bus_dout = bdout_q;
    assign dout     = dout_q;
    assign RnW      = rnw_q;
    assign ASn      = asn_q;
    assign UDSn     = udsn_q;
    assign LDSn     = ldsn_q;
    assign ack      = ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_jts16_busmaster.sv
// Testbench for jts16_busmaster: directed transfers against a small DTACK
// target model, with a scoreboard monitor checking each ack/err pulse.
module tb_jts16_busmaster;
    import jts16_bus_pkg::*;

    localparam int AW  = 23;
    localparam int TMO = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          cpu_cen  = 1'b0;
    logic          cpu_cenb = 1'b0;
    logic          req      = 1'b0;
    logic          we       = 1'b0;
    logic [AW-1:0] addr     = '0;
    logic [15:0]   din      = '0;
    logic [1:0]    dsn      = 2'b11;
    logic [15:0]   dout;
    logic          ack, err, busy;
    logic [AW-1:0] A;
    logic [15:0]   bus_dout;
    logic [15:0]   bus_din  = '0;
    logic          RnW, ASn, UDSn, LDSn;
    logic          DTACKn   = 1'b1;

    jts16_busmaster #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb),
        .req(req), .we(we), .addr(addr), .din(din), .dsn(dsn),
        .dout(dout), .ack(ack), .err(err), .busy(busy),
        .A(A), .bus_dout(bus_dout), .bus_din(bus_din),
        .RnW(RnW), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .DTACKn(DTACKn)
    );

    always #5 clk = ~clk;

    int chk_total = 0;
    int chk_pass  = 0;
    int clk_n     = 0;

    always @(posedge clk) clk_n <= clk_n + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0d clk)", nm, act, exp, clk_n);
    endtask

    // Environment: CPU enables (cen at phase 0, cenb at phase 2 of 4) and a DTACK target
    int ph        = 3;
    int w_cnt     = 0;
    int hold_cnt  = 0;
    int tgt_waits = 0;
    int tgt_hold  = 0;
    bit tgt_stuck = 1'b0;

    always @(negedge clk) begin
        ph       = (ph + 1) % 4;
        cpu_cen  = (ph == 0);
        cpu_cenb = (ph == 2);
        if (ASn === 1'b0) begin
            hold_cnt = tgt_hold;
            if (cpu_cenb) begin
                if (tgt_stuck) DTACKn = 1'b1;
                else if (w_cnt < tgt_waits) begin
                    w_cnt++;
                    DTACKn = 1'b1;
                end else DTACKn = 1'b0;
            end
        end else begin
            w_cnt = 0;
            if (hold_cnt > 0) hold_cnt--;
            else DTACKn = 1'b1;
        end
    end

    // Scoreboard
    typedef struct {
        bit          is_err;
        bit          rnw;
        logic [15:0] dout;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   fall_t   = 0;
    logic asn_prev = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (asn_prev === 1'b1 && ASn === 1'b0) fall_t = clk_n;
        asn_prev = ASn;
        if (ack === 1'b1 || err === 1'b1) begin
            if (q.size() == 0) check("unexpected_done", {ack, err}, 2'b00);
            else begin
                e = q.pop_front();
                check("done_kind", {ack, err}, e.is_err ? 2'b01 : 2'b10);
                check("done_latency", clk_n - fall_t, e.lat);
                check("dout", dout, e.dout);
                check("strobes_released", {ASn, UDSn, LDSn}, 3'b111);
                check("rnw_at_done", RnW, e.rnw);
            end
        end
    end

    logic [15:0] model_dout = '0;

    task automatic wait_busy(input logic v);
        for (int i = 0; i < 400 && busy !== v; i++) @(negedge clk);
        check("wait_busy", busy, v);
    endtask

    task automatic do_xfer(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                           input logic [1:0] ds, input int waits, input bit exp_err,
                           input logic [15:0] bdin, output int t_fall, output int t_done);
        exp_t e;
        tgt_waits = waits;
        tgt_stuck = exp_err;
        bus_din   = bdin;
        we = w; addr = a; din = d; dsn = ds; req = 1'b1;
        if (!w && !exp_err) model_dout = bdin;
        e.is_err = exp_err;
        e.rnw    = exp_err ? 1'b1 : !w;
        e.dout   = model_dout;
        e.lat    = exp_err ? (TMO * 4 + 1) : (8 + 4 * waits);
        q.push_back(e);
        wait_busy(1'b0);
        wait_busy(1'b1);
        check("addr_latched", A, a);
        check("rnw_drive", RnW, !w);
        check("bus_dout", bus_dout, d);
        // Inputs change after acceptance; the cycle must use the latched values
        req = 1'b0; addr = ~a; din = ~d; dsn = ~ds;
        for (int i = 0; i < 40 && ASn !== 1'b0; i++) @(negedge clk);
        check("asn_fall", ASn, 1'b0);
        t_fall = clk_n;
        check("strobes_at_as", {UDSn, LDSn}, w ? 2'b11 : ds);
        repeat (2) @(negedge clk);
        check("strobes_after_cen", {UDSn, LDSn}, ds);
        check("asn_held", ASn, 1'b0);
        for (int i = 0; i < 400 && ack !== 1'b1 && err !== 1'b1; i++) @(negedge clk);
        check("done_seen", ack | err, 1'b1);
        t_done    = clk_n;
        tgt_stuck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tf1, td1, tf2, td2;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_strobes", {ASn, UDSn, LDSn, RnW}, 4'b1111);
        check("rst_flags", {ack, err, busy}, 3'b000);
        check("rst_A", A, '0);
        check("rst_bus_dout", bus_dout, 16'h0);
        check("rst_dout", dout, 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Zero-wait word read, then a back-to-back upper-byte read
        do_xfer(1'b0, 23'h10_0000, 16'h0000, DSN_WORD, 0, 1'b0, 16'hBEEF, tf1, td1);
        do_xfer(1'b0, 23'h10_0001, 16'h0000, DSN_HI, 0, 1'b0, 16'h1234, tf2, td2);
        check("b2b_accept_gap", tf2 - td1, 8);

        // Lower-byte write with three wait states
        do_xfer(1'b1, 23'h02_0040, 16'h12AB, DSN_LO, 3, 1'b0, 16'h0000, tf1, td1);

        // Illegal strobes: cycle still runs with AS only
        do_xfer(1'b1, 23'h00_0123, 16'h5555, 2'b11, 0, 1'b0, 16'h0000, tf1, td1);

`ifdef JTS16_BUSMASTER_TIMEOUT_EN
        // DTACKn stuck high: abort with err, dout keeps the last read value
        do_xfer(1'b0, 23'h7F_FFFF, 16'h0000, DSN_WORD, 0, 1'b1, 16'hDEAD, tf1, td1);
`else
        // No timeout in this build: a long wait still completes
        do_xfer(1'b0, 23'h7F_FFFF, 16'h0000, DSN_WORD, 6, 1'b0, 16'hCAFE, tf1, td1);
`endif

        // Target keeps DTACKn low 10 clocks after AS release: next cycle is held off
        tgt_hold = 10;
        do_xfer(1'b0, 23'h00_0800, 16'h0000, DSN_WORD, 0, 1'b0, 16'hA1B2, tf1, td1);
        tgt_hold = 0;
        do_xfer(1'b0, 23'h00_0802, 16'h0000, DSN_WORD, 0, 1'b0, 16'hC3D4, tf2, td2);
        check("hold_accept_gap", tf2 - td1, 20);

        // Reset while waiting in S3
        tgt_stuck = 1'b1;
        we = 1'b0; addr = 23'h00_4000; dsn = DSN_WORD; req = 1'b1;
        wait_busy(1'b1);
        req = 1'b0;
        for (int i = 0; i < 40 && ASn !== 1'b0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_strobes", {ASn, UDSn, LDSn, RnW}, 4'b1111);
        check("midrst_flags", {ack, err, busy}, 3'b000);
        rst = 1'b0;
        tgt_stuck  = 1'b0;
        model_dout = 16'h0000;
        repeat (12) @(negedge clk);
        do_xfer(1'b0, 23'h00_4000, 16'h0000, DSN_WORD, 1, 1'b0, 16'h5A5A, tf1, td1);

        repeat (12) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
